// File: rtl/rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and default constants for the reset sequencer.
//   state_t     : sequencer phase (assert all / staggered release / done)
//   DEF_*       : default parameter values used by rst_seq_ctrl
//   max_int     : helper used to size the shared phase counter
// ----------------------------------------------------------------------------
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_STAGES_NUM  = 2;
  localparam int DEF_MIN_ASSERT  = 4;
  localparam int DEF_RELEASE_GAP = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_bit_sync.sv
// ----------------------------------------------------------------------------
// bit_sync
// Plain multi-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  : destination clock
//   rst  : synchronous active-low reset, clears every stage to 0
//   d    : asynchronous input
//   q    : synchronized output (last stage)
// ----------------------------------------------------------------------------
module bit_sync #(
  parameter int STAGES_NUM = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES_NUM-1:0] sync_ff;

  // Shift chain: d enters at bit 0, q is taken from the top bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES_NUM-2:0], d};
    end
  end

  assign q = sync_ff[STAGES_NUM-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl
// Reset sequencer: holds all channel resets low for MIN_ASSERT cycles, then
// releases them one at a time in index order, RELEASE_GAP cycles apart.
// A rising edge on the (synchronized) software request restarts the sequence.
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous active-low reset
//   sw_rst_req : asynchronous software reset request (rising edge acts)
//   ch_rst_n   : per-channel active-low resets, bit 0 released first
//   seq_done   : high while every channel is released
//   busy       : high during the assert and release phases
// All outputs are registered.
// ----------------------------------------------------------------------------
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int STAGES_NUM  = DEF_STAGES_NUM,
  parameter int MIN_ASSERT  = DEF_MIN_ASSERT,
  parameter int RELEASE_GAP = DEF_RELEASE_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              seq_done,
  output logic              busy
);

  // Counter only has to reach the longer of the two phase lengths minus one.
  localparam int CNT_MAX = max_int(MIN_ASSERT, RELEASE_GAP);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [IDX_W-1:0]   idx, nxt_idx;
  logic [NUM_CH-1:0]  nxt_ch;
  logic               nxt_done;
  logic               nxt_busy;
  logic               req_sync;
  logic               req_hist;
  logic               req_edge;

  bit_sync #(
    .STAGES_NUM (STAGES_NUM)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_rst_req),
    .q   (req_sync)
  );

  // Only a 0->1 transition of the synchronized request restarts the
  // sequence, so a request held high does not retrigger.
  assign req_edge = req_sync & ~req_hist;

  // State, counters and registered outputs. Reset wins over any request
  // edge seen on the same clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      idx      <= '0;
      req_hist <= 1'b0;
      ch_rst_n <= '0;
      seq_done <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      idx      <= nxt_idx;
      req_hist <= req_sync;
      ch_rst_n <= nxt_ch;
      seq_done <= nxt_done;
      busy     <= nxt_busy;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle early
  // so that the registered versions change on the same edge as the state.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_ch    = ch_rst_n;
    nxt_done  = seq_done;
    nxt_busy  = busy;

    if (req_edge) begin
      nxt_state = ST_ASSERT;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_ch    = '0;
      nxt_done  = 1'b0;
      nxt_busy  = 1'b1;
    end else begin
      case (state)
        ST_ASSERT: begin
          nxt_ch   = '0;
          nxt_done = 1'b0;
          nxt_busy = 1'b1;
          if (cnt == CNT_W'(MIN_ASSERT - 1)) begin
            nxt_cnt = '0;
            if (NUM_CH == 1) begin
              // Single channel: the first release is also the last.
              nxt_state = ST_DONE;
              nxt_idx   = '0;
              nxt_ch    = '1;
              nxt_done  = 1'b1;
              nxt_busy  = 1'b0;
            end else begin
              nxt_state = ST_RELEASE;
              nxt_idx   = IDX_W'(1);
              nxt_ch    = NUM_CH'(1);
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt == CNT_W'(RELEASE_GAP - 1)) begin
            nxt_cnt = '0;
            for (int i = 0; i < NUM_CH; i++) begin
              if (IDX_W'(i) == idx) begin
                nxt_ch[i] = 1'b1;
              end
            end
            nxt_idx = idx + IDX_W'(1);
            if (idx == IDX_W'(NUM_CH - 1)) begin
              nxt_state = ST_DONE;
              nxt_idx   = '0;
              nxt_done  = 1'b1;
              nxt_busy  = 1'b0;
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          nxt_ch   = '1;
          nxt_done = 1'b1;
          nxt_busy = 1'b0;
        end

        default: begin
          nxt_state = ST_ASSERT;
          nxt_cnt   = '0;
          nxt_idx   = '0;
          nxt_ch    = '0;
          nxt_done  = 1'b0;
          nxt_busy  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Directed testbench for rst_seq_ctrl: default configuration plus a
// single-channel, MIN_ASSERT=1 instance sharing clock and reset.
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic [3:0] ch_rst_n;
  logic       seq_done;
  logic       busy;

  logic       sw_rst_req_1;
  logic [0:0] ch_rst_n_1;
  logic       seq_done_1;
  logic       busy_1;

  int total_checks = 0;
  int bad_checks   = 0;

  rst_seq_ctrl #(
    .NUM_CH      (4),
    .STAGES_NUM  (2),
    .MIN_ASSERT  (4),
    .RELEASE_GAP (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .ch_rst_n   (ch_rst_n),
    .seq_done   (seq_done),
    .busy       (busy)
  );

  rst_seq_ctrl #(
    .NUM_CH      (1),
    .STAGES_NUM  (2),
    .MIN_ASSERT  (1),
    .RELEASE_GAP (8)
  ) dut_one (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req_1),
    .ch_rst_n   (ch_rst_n_1),
    .seq_done   (seq_done_1),
    .busy       (busy_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected channel resets n edges into a default-config sequence.
  function automatic logic [3:0] expCh(input int n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (n >= 4 + 8 * i);
    return r;
  endfunction

  // Check all three outputs against edge n of a fresh sequence.
  task automatic checkSeq(input string tag, input int n);
    checkOutput($sformatf("%s ch n%0d", tag, n), 32'(ch_rst_n), 32'(expCh(n)));
    checkOutput($sformatf("%s done n%0d", tag, n), 32'(seq_done), 32'(n >= 28));
    checkOutput($sformatf("%s busy n%0d", tag, n), 32'(busy), 32'(n < 28));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " ch"}, 32'(ch_rst_n), 32'h0);
    checkOutput({tag, " done"}, 32'(seq_done), 32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'h1);
  endtask

  initial begin
    rst          = 1'b0;
    sw_rst_req   = 1'b0;
    sw_rst_req_1 = 1'b0;

    // Power-up: reset held three cycles, then the full release sequence.
    repeat (3) tick();
    checkReset("pwr rst");
    checkOutput("one rst ch", 32'(ch_rst_n_1), 32'h0);
    checkOutput("one rst done", 32'(seq_done_1), 32'h0);
    checkOutput("one rst busy", 32'(busy_1), 32'h1);
    rst = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      checkSeq("pwr", n);
      if (n == 1) begin
        checkOutput("one e1 ch", 32'(ch_rst_n_1), 32'h1);
        checkOutput("one e1 done", 32'(seq_done_1), 32'h1);
        checkOutput("one e1 busy", 32'(busy_1), 32'h0);
      end
    end

    // Software request while done, held high for three cycles.
    sw_rst_req = 1'b1;
    for (int j = 0; j <= 34; j++) begin
      tick();
      if (j == 2) sw_rst_req = 1'b0;
      if (j < 2) checkSeq("swdone", 99);
      else checkSeq("swdone", j - 2);
    end

    // Request mid-release (0011), then held 100 cycles without retrigger.
    rst = 1'b0;
    tick();
    checkReset("mid rst");
    rst = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checkSeq("mid pre", n);
    end
    sw_rst_req = 1'b1;
    for (int j = 0; j <= 109; j++) begin
      tick();
      if (j == 99) sw_rst_req = 1'b0;
      if (j < 2) checkSeq("mid", 13 + j);
      else checkSeq("mid", j - 2);
    end

    // Reset mid-sequence with a request edge landing on the same edge.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checkSeq("rstmid pre", n);
    end
    sw_rst_req = 1'b1;
    tick();
    checkSeq("rstmid", 13);
    tick();
    checkSeq("rstmid", 14);
    sw_rst_req = 1'b0;
    rst        = 1'b0;
    tick();
    checkReset("rstmid e15");
    rst = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      checkSeq("rstmid post", n);
    end

    // One-cycle glitch: outputs must always be an ascending released prefix.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    for (int j = 0; j <= 40; j++) begin
      tick();
      checkOutput($sformatf("glitch prefix j%0d", j),
                  32'((ch_rst_n & (ch_rst_n + 4'd1)) == 4'd0), 32'h1);
      checkOutput($sformatf("glitch busy j%0d", j),
                  32'(busy), 32'(ch_rst_n != 4'hF));
    end
    checkOutput("glitch final ch", 32'(ch_rst_n), 32'hF);
    checkOutput("glitch final done", 32'(seq_done), 32'h1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
